// File: rtl/pspin_cfg_pkg.sv
// pspin_cfg_pkg: shared NIC command types and widths
package pspin_cfg_pkg;
  localparam int NIC_CMD_ID_W  = 8;
  localparam int NIC_REQ_IDX_W = 4;
  typedef struct packed {
    logic [NIC_CMD_ID_W-1:0] cmd_id;
    logic [31:0]             data;
  } pspin_cmd_req_t;
  typedef struct packed {
    logic [NIC_CMD_ID_W-1:0] cmd_id;
    logic [7:0]              status;
  } pspin_cmd_resp_t;
  typedef struct packed {
    logic                     used;
    logic [NIC_REQ_IDX_W-1:0] req_idx;
    logic [NIC_CMD_ID_W-1:0]  orig_id;
  } nic_cmd_slot_t;
endpackage

// File: rtl/rr_arb_sel.sv
// rr_arb_sel: combinational round-robin search, first valid at or after the pointer
module rr_arb_sel #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);
  // scan farthest-to-nearest so the nearest valid requester wins
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (valid_i[(int'(ptr_i) + i) % N]) idx_o = W'((int'(ptr_i) + i) % N);
  end
  assign gnt_o = |valid_i ? N'(1) << idx_o : '0;
endmodule

// File: rtl/nic_cmd_arbiter.sv
// nic_cmd_arbiter: shares the NIC command port, remapping cmd_id to table slots
import pspin_cfg_pkg::*;
module nic_cmd_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  pspin_cmd_req_t [NUM_REQ-1:0]        req_cmd_i,
  output logic [NUM_REQ-1:0]                  resp_valid_o,
  output pspin_cmd_resp_t                     resp_o,
  output logic                                nic_cmd_valid_o,
  input  logic                                nic_cmd_ready_i,
  output pspin_cmd_req_t                      nic_cmd_o,
  input  logic                                nic_cmd_resp_valid_i,
  input  pspin_cmd_resp_t                     nic_cmd_resp_i,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_o,
  output logic                                busy_o,
  output logic                                err_unknown_id_o
);
  localparam int SW = $clog2(MAX_OUTSTANDING);
  localparam int RW = $clog2(NUM_REQ);
  localparam int OW = SW + 1;
  nic_cmd_slot_t   slot_q [MAX_OUTSTANDING];
  nic_cmd_slot_t   slot_d [MAX_OUTSTANDING];
  logic [RW-1:0]   rr_q, rr_d, win_idx;
  logic [NUM_REQ-1:0] win_oh, resp_valid_q, resp_valid_d;
  logic            free_ok, grant, hit, nic_valid_q, nic_valid_d, err_q, err_d;
  logic [SW-1:0]   free_idx, rid;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  pspin_cmd_req_t  nic_cmd_q, nic_cmd_d;
  pspin_cmd_resp_t resp_q, resp_d;
  rr_arb_sel #(.N(NUM_REQ)) u_sel (
    .valid_i(req_valid_i),
    .ptr_i  (rr_q),
    .gnt_o  (win_oh),
    .idx_o  (win_idx)
  );
  // lowest unused slot, from registered state only so a freed slot waits a cycle
  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--)
      if (!slot_q[i].used) begin
        free_ok  = 1'b1;
        free_idx = SW'(i);
      end
  end
  assign grant = !rst_i && |req_valid_i && free_ok && (!nic_valid_q || nic_cmd_ready_i);
  assign req_ready_o = grant ? win_oh : '0;
  assign rid = nic_cmd_resp_i.cmd_id[SW-1:0];
  assign hit = nic_cmd_resp_valid_i && int'(nic_cmd_resp_i.cmd_id) < MAX_OUTSTANDING && slot_q[rid].used;
  // next state: slot table update, output/response registers, counters
  always_comb begin
    slot_d = slot_q;
    if (hit) slot_d[rid].used = 1'b0;
    if (grant) slot_d[free_idx] = '{used: 1'b1, req_idx: NIC_REQ_IDX_W'(win_idx),
                                    orig_id: req_cmd_i[win_idx].cmd_id};
    nic_cmd_d = req_cmd_i[win_idx];
    nic_cmd_d.cmd_id = NIC_CMD_ID_W'(free_idx);
    nic_cmd_d = grant ? nic_cmd_d : nic_cmd_q;
    nic_valid_d = grant || (nic_valid_q && !nic_cmd_ready_i);
    resp_valid_d = hit ? NUM_REQ'(1) << slot_q[rid].req_idx : '0;
    resp_d = hit ? '{cmd_id: slot_q[rid].orig_id, status: nic_cmd_resp_i.status} : resp_q;
    outstanding_d = outstanding_q + OW'(grant) - OW'(hit);
    rr_d = !grant ? rr_q : (win_idx == RW'(NUM_REQ - 1)) ? '0 : win_idx + RW'(1);
    err_d = err_q || (nic_cmd_resp_valid_i && !hit);
  end
  // state registers with synchronous reset discarding all in-flight state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) slot_q[i] <= '0;
      nic_cmd_q     <= '0;
      nic_valid_q   <= 1'b0;
      resp_valid_q  <= '0;
      resp_q        <= '0;
      outstanding_q <= '0;
      rr_q          <= '0;
      err_q         <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      nic_cmd_q     <= nic_cmd_d;
      nic_valid_q   <= nic_valid_d;
      resp_valid_q  <= resp_valid_d;
      resp_q        <= resp_d;
      outstanding_q <= outstanding_d;
      rr_q          <= rr_d;
      err_q         <= err_d;
    end
  end
  assign nic_cmd_valid_o  = nic_valid_q;
  assign nic_cmd_o        = nic_cmd_q;
  assign resp_valid_o     = resp_valid_q;
  assign resp_o           = resp_q;
  assign outstanding_o    = outstanding_q;
  assign busy_o           = outstanding_q != '0 || nic_valid_q;
  assign err_unknown_id_o = err_q;
endmodule

// File: tb/tb_nic_cmd_arbiter.sv
// tb_nic_cmd_arbiter: directed self-checking bench for nic_cmd_arbiter
import pspin_cfg_pkg::*;
module tb_nic_cmd_arbiter;
  logic clk = 1'b0, rst;
  logic [3:0] req_valid, req_ready, resp_valid;
  pspin_cmd_req_t [3:0] req_cmd;
  pspin_cmd_resp_t resp, nic_resp;
  logic nic_valid, nic_ready, nic_resp_valid, busy, err;
  pspin_cmd_req_t nic_cmd;
  logic [3:0] outstanding;
  int checks = 0, errors = 0;
  int cnt [4];
  always #5 clk = ~clk;
  nic_cmd_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cmd_i(req_cmd),
    .resp_valid_o(resp_valid), .resp_o(resp),
    .nic_cmd_valid_o(nic_valid), .nic_cmd_ready_i(nic_ready), .nic_cmd_o(nic_cmd),
    .nic_cmd_resp_valid_i(nic_resp_valid), .nic_cmd_resp_i(nic_resp),
    .outstanding_o(outstanding), .busy_o(busy), .err_unknown_id_o(err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, " ready"}, req_ready, 0);
    chk({tag, " nic_valid"}, nic_valid, 0);
    chk({tag, " nic_cmd"}, nic_cmd, 0);
    chk({tag, " resp_valid"}, resp_valid, 0);
    chk({tag, " resp"}, resp, 0);
    chk({tag, " outstanding"}, outstanding, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " err"}, err, 0);
  endtask
  initial begin
    rst = 1'b1; req_valid = '0; req_cmd = '0; nic_ready = 1'b1;
    nic_resp_valid = 1'b0; nic_resp = '0;
    step(); step();
    rst = 1'b0;
    #1 chk_reset_vals("reset");
    // single command
    req_valid = 4'b0001; req_cmd[0] = '{cmd_id: 8'h05, data: 32'hA0A0_0001};
    #1 chk("single ready", req_ready, 4'b0001);
    step(); req_valid = '0;
    chk("single nic_valid", nic_valid, 1);
    chk("single nic_cmd", nic_cmd, {8'h00, 32'hA0A0_0001});
    chk("single outstanding", outstanding, 1);
    chk("single busy", busy, 1);
    step();
    chk("single drained", nic_valid, 0);
    nic_resp_valid = 1'b1; nic_resp = '{cmd_id: 8'h00, status: 8'h33};
    step(); nic_resp_valid = 1'b0;
    chk("single resp_valid", resp_valid, 4'b0001);
    chk("single resp", resp, {8'h05, 8'h33});
    chk("single outstanding0", outstanding, 0);
    step();
    chk("single resp pulse", resp_valid, 0);
    chk("single idle", busy, 0);
    // unknown completions
    nic_resp_valid = 1'b1; nic_resp = '{cmd_id: 8'h06, status: 8'h01};
    step(); nic_resp_valid = 1'b0;
    chk("unk6 resp_valid", resp_valid, 0);
    chk("unk6 err", err, 1);
    chk("unk6 outstanding", outstanding, 0);
    nic_resp_valid = 1'b1; nic_resp = '{cmd_id: 8'h09, status: 8'h02};
    step(); nic_resp_valid = 1'b0;
    chk("unk9 resp_valid", resp_valid, 0);
    chk("unk9 err", err, 1);
    step();
    chk("err sticky", err, 1);
    // round-robin fairness with immediate completions
    do_reset();
    for (int r = 0; r < 4; r++) begin
      cnt[r] = 0;
      req_cmd[r] = '{cmd_id: 8'(8'h10 + r), data: 32'(r)};
    end
    for (int k = 0; k < 100; k++) begin
      req_valid = 4'b1111;
      nic_resp_valid = nic_valid;
      nic_resp = '{cmd_id: nic_cmd.cmd_id, status: 8'h00};
      #1 chk("rr order", req_ready, 4'b0001 << (k % 4));
      for (int r = 0; r < 4; r++) if (req_ready[r]) cnt[r]++;
      step();
    end
    req_valid = '0;
    nic_resp_valid = nic_valid;
    nic_resp = '{cmd_id: nic_cmd.cmd_id, status: 8'h00};
    step(); nic_resp_valid = 1'b0;
    step();
    for (int r = 0; r < 4; r++) chk("rr count", cnt[r], 25);
    chk("rr drained", outstanding, 0);
    // table full
    do_reset();
    req_valid = 4'b0001; req_cmd[0] = '{cmd_id: 8'h07, data: 32'h1234};
    for (int k = 0; k < 8; k++) begin
      #1 chk("fill ready", req_ready, 4'b0001);
      step();
    end
    #1 chk("full ready", req_ready, 0);
    chk("full outstanding", outstanding, 8);
    nic_resp_valid = 1'b1; nic_resp = '{cmd_id: 8'h03, status: 8'h00};
    #1 chk("full ready same cycle", req_ready, 0);
    step(); nic_resp_valid = 1'b0;
    #1 chk("freed ready", req_ready, 4'b0001);
    chk("freed outstanding", outstanding, 7);
    chk("freed resp_valid", resp_valid, 4'b0001);
    step(); req_valid = '0;
    chk("reuse slot", nic_cmd.cmd_id, 3);
    chk("reuse outstanding", outstanding, 8);
    // NIC backpressure
    do_reset();
    nic_ready = 1'b0;
    req_valid = 4'b0001;
    req_cmd[0] = '{cmd_id: 8'h11, data: 32'hDEAD_0000};
    req_cmd[1] = '{cmd_id: 8'h22, data: 32'hBEEF_0001};
    #1 chk("bp first ready", req_ready, 4'b0001);
    step(); req_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      #1 chk("bp stall ready", req_ready, 0);
      chk("bp hold cmd", nic_cmd, {8'h00, 32'hDEAD_0000});
      chk("bp hold valid", nic_valid, 1);
      step();
    end
    chk("bp held count", outstanding, 1);
    nic_ready = 1'b1;
    #1 chk("bp release ready", req_ready, 4'b0010);
    step(); req_valid = '0;
    chk("bp next cmd", nic_cmd, {8'h01, 32'hBEEF_0001});
    chk("bp outstanding", outstanding, 2);
    // grant and completion in the same cycle
    req_valid = 4'b0100; req_cmd[2] = '{cmd_id: 8'h33, data: 32'hCAFE_0002};
    nic_resp_valid = 1'b1; nic_resp = '{cmd_id: 8'h00, status: 8'h7E};
    #1 chk("sim ready", req_ready, 4'b0100);
    step(); req_valid = '0; nic_resp_valid = 1'b0;
    chk("sim outstanding", outstanding, 2);
    chk("sim resp_valid", resp_valid, 4'b0001);
    chk("sim resp", resp, {8'h11, 8'h7E});
    chk("sim nic_cmd", nic_cmd, {8'h02, 32'hCAFE_0002});
    req_valid = 4'b1000; req_cmd[3] = '{cmd_id: 8'h44, data: 32'hF00D_0003};
    #1 chk("sim ready3", req_ready, 4'b1000);
    step(); req_valid = '0;
    chk("sim slot0 reuse", nic_cmd.cmd_id, 0);
    chk("sim outstanding3", outstanding, 3);
    // reset with commands outstanding
    rst = 1'b1;
    step();
    chk_reset_vals("midrst");
    rst = 1'b0;
    nic_resp_valid = 1'b1; nic_resp = '{cmd_id: 8'h01, status: 8'h00};
    step(); nic_resp_valid = 1'b0;
    chk("stale resp_valid", resp_valid, 0);
    chk("stale err", err, 1);
    chk("stale outstanding", outstanding, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nic_cmd_arbiter.md
# nic_cmd_arbiter

Shares the single PsPIN outbound NIC command port (`nic_cmd_*`) among `NUM_REQ` command sources (cluster command units). It round-robin arbitrates requests, remaps each command's `cmd_id` to a free slot of an outstanding-command table, and routes NIC completions back to the issuing requester with the original `cmd_id` restored. It sits between the cluster command units and the `nic_cmd_o` / `nic_cmd_resp_i` boundary of `pspin`.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be at least 2.
- `MAX_OUTSTANDING`, default 8: number of table slots; must be a power of 2 and at most 2^`NIC_CMD_ID_W`.
- `clk_i`, input, 1 bit: the single clock.
- `rst_i`, input, 1 bit: reset, synchronous, active-high.
- `req_valid_i`, input, `NUM_REQ` bits: per-requester command valid.
- `req_ready_o`, output, `NUM_REQ` bits: per-requester command accept.
- `req_cmd_i`, input, `NUM_REQ` × `pspin_cmd_req_t`: per-requester command.
- `resp_valid_o`, output, `NUM_REQ` bits: one-hot completion pulse to the requester that owns the completion.
- `resp_o`, output, `pspin_cmd_resp_t`: completion carrying the original `cmd_id`; shared by all requesters.
- `nic_cmd_valid_o`, output, 1 bit: command valid toward the NIC.
- `nic_cmd_ready_i`, input, 1 bit: NIC accept.
- `nic_cmd_o`, output, `pspin_cmd_req_t`: command with `cmd_id` replaced by the slot index (zero-extended).
- `nic_cmd_resp_valid_i`, input, 1 bit: NIC completion valid; there is no ready.
- `nic_cmd_resp_i`, input, `pspin_cmd_resp_t`: NIC completion; its `cmd_id` is a slot index.
- `outstanding_o`, output, clog2(`MAX_OUTSTANDING`)+1 bits: number of occupied slots.
- `busy_o`, output, 1 bit: high when `outstanding_o` ≠ 0 or `nic_cmd_valid_o` = 1.
- `err_unknown_id_o`, output, 1 bit: sticky error; cleared only by reset.

## Operation
- **Slot table.** Each of `MAX_OUTSTANDING` entries holds `{used, req_idx, orig_id}`.
- **Free slot selection.** The free slot is the lowest-index entry with `used` = 0, computed from registered state only.
- **Grant condition.** A grant happens when all of the following hold: some `req_valid_i` is high, a free slot exists, and the output register is empty or is draining this cycle (`nic_cmd_valid_o` & `nic_cmd_ready_i`).
- **Winner selection.** The winner is the first valid requester at or after the round-robin pointer `rr_q`, searching with wrap-around.
- **On grant.**
  - `req_ready_o[winner]` = 1; every other ready stays 0.
  - The output register loads the command with `cmd_id` set to the slot index.
  - The slot is marked used and records the winner index and the original `cmd_id`.
  - `rr_q` becomes (winner+1) mod `NUM_REQ`.
- **Ready is combinational** from `req_valid_i` and state. A requester must not make `valid` depend on `ready`.
- **Table full.** All ready outputs are 0. `rr_q` does not change.
- **Completion handling** (when `nic_cmd_resp_valid_i` is high):
  - Look up the slot at `cmd_id[clog2(MAX_OUTSTANDING)-1:0]`.
  - If the slot is used: register `resp_o` (the completion with `cmd_id` = `orig_id`) and a one-hot `resp_valid_o[req_idx]`, then clear `used`.
  - If `cmd_id` ≥ `MAX_OUTSTANDING` or the slot is unused: drop the completion, set `err_unknown_id_o`, and produce no `resp_valid_o`.
- **Grant and completion in the same cycle.**
  - The freed slot becomes allocatable from the next cycle.
  - `outstanding_o` updates by +1−1, i.e. it stays unchanged.
  - No conflict is possible: allocation only picks unused slots, and a completion only frees a used slot.

## Timing
- **Reset values:** `req_ready_o` = 0, `nic_cmd_valid_o` = 0, `nic_cmd_o` = '0, `resp_valid_o` = 0, `resp_o` = '0, `outstanding_o` = 0, `busy_o` = 0, `err_unknown_id_o` = 0, all `used` bits = 0, `rr_q` = 0.
- **Reset mid-operation:** all in-flight state is discarded. Completions for pre-reset commands arriving after reset are flagged as unknown.
- **Command latency:** a request accepted in cycle t appears on `nic_cmd_valid_o` in cycle t+1.
- **Back-to-back throughput:** one command per cycle while `nic_cmd_ready_i` stays high and slots remain.
- **Output handshake:** once `nic_cmd_valid_o` is asserted, it and `nic_cmd_o` stay stable until `nic_cmd_ready_i` is sampled high.
- **Completion latency:** a completion in cycle t produces `resp_valid_o` for exactly one cycle in t+1. Completions may arrive every cycle.
- **`outstanding_o` update:** increments in the cycle after a grant and decrements in the cycle after a valid completion.

## Structure
- In `pspin_cfg_pkg`: `NIC_CMD_ID_W`, the `cmd_id` fields of `pspin_cmd_req_t` and `pspin_cmd_resp_t`, and a `nic_cmd_slot_t` struct `{used, req_idx, orig_id}`.
- One sub-module, `rr_arb_sel`: a combinational round-robin priority search with inputs valid vector and pointer, and outputs one-hot grant and index.
- Slot table, output register, and response register live in `nic_cmd_arbiter`.

## Test plan
- **Single command:** after reset, req0 sends a command with `cmd_id` = 0x5 and the NIC is always ready → `nic_cmd_o.cmd_id` = 0 at t+1. The NIC later returns id 0 → `resp_valid_o` = 4'b0001 and `resp_o.cmd_id` = 0x5.
- **Round-robin fairness:** all 4 requesters valid continuously, NIC always ready, completions returned immediately → grant order is 0,1,2,3,0,… and each requester gets exactly 25 of 100 grants.
- **Table full:** `MAX_OUTSTANDING` = 8, NIC ready, no completions → 8 grants, then `req_ready_o` = 0 and `outstanding_o` = 8. Returning slot 3 → the next grant uses slot 3 one cycle after the completion.
- **NIC backpressure:** `nic_cmd_ready_i` held low for 10 cycles → `nic_cmd_o` stays stable, exactly one command is held, and no further grants occur. Releasing ready → the held command is accepted and the next request is granted in that same cycle.
- **Unknown completions:** a completion with id 6 while slot 6 is unused, and a completion with id ≥ 8 → no `resp_valid_o`, `err_unknown_id_o` = 1 and stays set, `outstanding_o` unchanged.
- **Simultaneous grant, completion, and reset:** a grant and a completion in the same cycle → `outstanding_o` unchanged. Asserting `rst_i` with 3 commands outstanding → all outputs return to their reset values the next cycle.
